// File: rtl/instr_loader.sv
// Instruction-memory program loader: assembles a big-endian byte stream into
// 32-bit words, writes them from address 0 upward and holds the CPU meanwhile.
module instr_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   n_words,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] MAX_W = (ADDR_W+1)'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]   words_left_q, words_left_d;
  logic [23:0]       shift_q, shift_d;
  logic [31:0]       wd_q, wd_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   n_sat;

  assign n_sat = (n_words > MAX_W) ? MAX_W : n_words;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      byte_cnt_q   <= '0;
      words_left_q <= '0;
      shift_q      <= '0;
      wd_q         <= '0;
      waddr_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      byte_cnt_q   <= byte_cnt_d;
      words_left_q <= words_left_d;
      shift_q      <= shift_d;
      wd_q         <= wd_d;
      waddr_q      <= waddr_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    byte_cnt_d   = byte_cnt_q;
    words_left_d = words_left_q;
    shift_d      = shift_q;
    wd_d         = wd_q;
    waddr_d      = waddr_q;
    err_d        = err_q;
    in_ready     = 1'b0;
    mem_we       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (n_words == '0) begin
            state_d = DONE;
          end else begin
            words_left_d = n_sat;
            addr_d       = '0;
            byte_cnt_d   = '0;
            state_d      = LOAD;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (in_valid) begin
          // The fourth byte goes straight into the write register so the
          // write can issue on the very next cycle.
          if (byte_cnt_q == 2'd3) begin
            wd_d    = {shift_q, in_data};
            waddr_d = addr_q;
            state_d = WRITE;
          end else begin
            shift_d    = {shift_q[15:0], in_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      WRITE: begin
        mem_we       = 1'b1;
        busy         = 1'b1;
        addr_d       = addr_q + 1'b1;
        words_left_d = words_left_q - 1'b1;
        byte_cnt_d   = '0;
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (words_left_q == (ADDR_W+1)'(1)) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr = waddr_q;
  assign mem_wd   = wd_q;
  assign cpu_hold = busy;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: scripted byte streams, a write monitor and
// hand-computed expected words/addresses.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  n_words = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_we, busy, cpu_hold, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wd;

  int n_checks = 0;
  int n_pass   = 0;

  int          we_cnt   = 0;
  int          done_cnt = 0;
  logic [31:0] tb_mem [256];
  logic [7:0]  log_addr [1024];
  logic [31:0] log_data [1024];

  instr_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_words(n_words), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr] <= mem_wd;
      if (we_cnt < 1024) begin
        log_addr[we_cnt] <= mem_addr;
        log_data[we_cnt] <= mem_wd;
      end
      we_cnt <= we_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [8:0] n, input logic with_abort);
    start = 1'b1; n_words = n; abort = with_abort;
    tick();
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (!in_ready) check("hs_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 0);
    send_byte(w[23:16], 0);
    send_byte(w[15:8], 0);
    send_byte(w[7:0], 0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 50) begin
      tick();
      t++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    tick();
  endtask

  logic [7:0] bs2 [8] = '{8'h20, 8'h01, 8'h00, 8'hCA, 8'h00, 8'h21, 8'h10, 8'h20};
  int         gp2 [8] = '{0, 2, 1, 3, 0, 1, 0, 4};

  initial begin
    int we0, dn0;
    #2;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_wd", mem_wd, 32'd0);
    #21 rst_n = 1'b1;
    tick();

    // 1-word load, back-to-back bytes
    we0 = we_cnt; dn0 = done_cnt;
    do_start(9'd1, 1'b0);
    check("t1_hold", {31'b0, cpu_hold}, 32'd1);
    check("t1_ready", {31'b0, in_ready}, 32'd1);
    send_word(32'h200100CA);
    check("t1_we", {31'b0, mem_we}, 32'd1);
    check("t1_addr", {24'b0, mem_addr}, 32'd0);
    check("t1_wd", mem_wd, 32'h200100CA);
    check("t1_ready_wr", {31'b0, in_ready}, 32'd0);
    tick();
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_busy_done", {31'b0, busy}, 32'd0);
    check("t1_hold_done", {31'b0, cpu_hold}, 32'd0);
    check("t1_we_off", {31'b0, mem_we}, 32'd0);
    check("t1_wd_hold", mem_wd, 32'h200100CA);
    tick();
    check("t1_done_off", {31'b0, done}, 32'd0);
    check("t1_writes", we_cnt - we0, 32'd1);
    check("t1_dones", done_cnt - dn0, 32'd1);

    // 2-word load with gaps
    we0 = we_cnt; dn0 = done_cnt;
    do_start(9'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_byte(bs2[i], gp2[i]);
      if (i == 3 || i == 7) begin
        check("t2_we", {31'b0, mem_we}, 32'd1);
        check("t2_ready_wr", {31'b0, in_ready}, 32'd0);
        check("t2_addr", {24'b0, mem_addr}, (i == 3) ? 32'd0 : 32'd1);
      end
    end
    wait_done();
    check("t2_mem0", tb_mem[0], 32'h200100CA);
    check("t2_mem1", tb_mem[1], 32'h00211020);
    check("t2_writes", we_cnt - we0, 32'd2);
    check("t2_dones", done_cnt - dn0, 32'd1);

    // zero-word load
    we0 = we_cnt; dn0 = done_cnt;
    do_start(9'd0, 1'b0);
    check("t3_done", {31'b0, done}, 32'd1);
    check("t3_busy", {31'b0, busy}, 32'd0);
    tick();
    check("t3_done_off", {31'b0, done}, 32'd0);
    check("t3_busy2", {31'b0, busy}, 32'd0);
    tick();
    check("t3_writes", we_cnt - we0, 32'd0);
    check("t3_dones", done_cnt - dn0, 32'd1);

    // abort mid word 1 of 3
    we0 = we_cnt; dn0 = done_cnt;
    do_start(9'd3, 1'b0);
    send_word(32'h11223344);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_busy", {31'b0, busy}, 32'd0);
    check("t4_err", {31'b0, err}, 32'd1);
    check("t4_ready", {31'b0, in_ready}, 32'd0);
    repeat (3) tick();
    check("t4_err_sticky", {31'b0, err}, 32'd1);
    check("t4_writes", we_cnt - we0, 32'd1);
    check("t4_mem0", tb_mem[0], 32'h11223344);
    check("t4_dones", done_cnt - dn0, 32'd0);
    // start with simultaneous abort: start wins and clears err
    do_start(9'd1, 1'b1);
    check("t4_err_clr", {31'b0, err}, 32'd0);
    check("t4_restart_busy", {31'b0, busy}, 32'd1);
    send_word(32'hCAFEF00D);
    wait_done();
    check("t4_mem0b", tb_mem[0], 32'hCAFEF00D);

    // asynchronous reset mid word
    we0 = we_cnt;
    do_start(9'd1, 1'b0);
    send_byte(8'h99, 0);
    send_byte(8'h88, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_ready", {31'b0, in_ready}, 32'd0);
    check("t5_hold", {31'b0, cpu_hold}, 32'd0);
    check("t5_wd", mem_wd, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_writes", we_cnt - we0, 32'd0);
    do_start(9'd1, 1'b0);
    send_word(32'hDEADBEEF);
    check("t5_we", {31'b0, mem_we}, 32'd1);
    wait_done();
    check("t5_mem0", tb_mem[0], 32'hDEADBEEF);
    check("t5_writes2", we_cnt - we0, 32'd1);

    // full 256-word load
    we0 = we_cnt; dn0 = done_cnt;
    do_start(9'd256, 1'b0);
    for (int i = 0; i < 256; i++) send_word(32'h10000000 + i);
    wait_done();
    repeat (3) tick();
    check("t6_writes", we_cnt - we0, 32'd256);
    check("t6_dones", done_cnt - dn0, 32'd1);
    for (int i = 0; i < 256; i++) begin
      check("t6_addr", {24'b0, log_addr[we0 + i]}, i);
      check("t6_data", log_data[we0 + i], 32'h10000000 + i);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Program loader that writes the writable instruction memory: the write-side counterpart of the combinational instruction read port (8-bit word address, 32-bit word).
- Accepts a byte stream over a valid/ready handshake.
- Assembles bytes big-endian into 32-bit instruction words.
- Writes the words to consecutive addresses starting at 0.
- Holds the CPU core in reset while loading and signals completion.

Parameters:
- ADDR_W, 8: instruction memory word-address width.
- MAX_WORDS, 256: maximum words per load; equals 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- n_words  input  ADDR_W+1  number of words to load (0..MAX_WORDS); sampled with start.
- abort  input  1  cancels a load in progress.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte.
- mem_we  output  1  instruction memory write enable; one-cycle pulse.
- mem_addr  output  ADDR_W  write word address.
- mem_wd  output  32  write data.
- busy  output  1  a load is in progress.
- cpu_hold  output  1  holds the CPU in reset; equals busy.
- done  output  1  one-cycle pulse when a load completes.
- err  output  1  sticky: the last load was aborted; cleared by the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, all outputs 0, internal address, byte count and word count cleared.
- Reset mid-load: the partial word is discarded and no write is issued; words already written stay in memory.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start with n_words>=1: latch n_words, addr=0, byte_cnt=0, err=0; go to LOAD.
  - start with n_words==0: err=0, go to DONE (done pulses next cycle, memory untouched).
  - n_words>MAX_WORDS is saturated to MAX_WORDS.
- LOAD:
  - in_ready=1, busy=1.
  - A byte transfers on a cycle where in_valid && in_ready.
  - Byte k (0..3) of a word goes to bits [31-8k:24-8k]; the first byte is the MSB.
  - in_valid low stalls with no state change; gaps of any length are allowed.
  - On the 4th byte: go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=addr, mem_wd=assembled word; in_ready=0.
  - Next cycle: addr+1, words_left-1, byte_cnt=0.
  - words_left reaching 0: go to DONE; otherwise go to LOAD.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Latency and throughput:
  - mem_we asserts the cycle after the 4th byte handshake.
  - Best case is 5 cycles per word.
  - done asserts the cycle after the final write.
- mem_addr and mem_wd hold their last values outside WRITE; only mem_we qualifies a write.
- abort in LOAD or WRITE:
  - Go to IDLE next cycle; err=1; no done pulse.
  - abort in the same cycle as WRITE: that write still occurs (mem_we already asserted), then abort.
  - abort in IDLE or DONE is ignored.
- start outside IDLE is ignored. start and abort together in IDLE: start wins (abort is ignored in IDLE).
- Address wrap: with n_words=MAX_WORDS the last write is at address MAX_WORDS-1. The internal address increment after it is never used.

Test Plan:
- n_words=1, bytes 20 01 00 CA back-to-back -> in_ready high for 4 cycles; mem_we one cycle later with addr 0, wd 0x200100CA; done the following cycle; cpu_hold high from the cycle after start until done.
- n_words=2, bytes 20 01 00 CA 00 21 10 20 with random in_valid gaps -> writes (0, 0x200100CA) then (1, 0x00211020); exactly 2 mem_we pulses; in_ready=0 during each WRITE cycle.
- start with n_words=0 -> no mem_we; done pulses once; busy stays 0.
- n_words=3, abort after byte 2 of word 1 -> exactly one write (addr 0); IDLE next cycle; err=1; no done. A new start clears err.
- rst_n driven low asynchronously mid-word (between clock edges) -> outputs 0 immediately; no write for the partial word. After release, a fresh 1-word load works normally.
- n_words=256 with incrementing words -> 256 writes at addresses 0..255 with matching data; done once; no write to address 0 after address 255.
